// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the instruction-ROM port arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package rom_arb_pkg;

    // Which requester wins when IF and DM contend in the same cycle
    typedef enum logic {
        PRIO_IF = 1'b0,
        PRIO_DM = 1'b1
    } owner_t;

    // Width of the consecutive-IF-grant counter; MAX_IF_STREAK must fit in it
    localparam int STREAK_W = 4;

    // Bit positions in the per-port grant vector
    localparam int IF_PORT = 0;
    localparam int DM_PORT = 1;

endpackage

// File: rtl/rom_arb_resp_reg.sv
// Per-port response register: captures ROM data on a grant and presents it next cycle.
// Latency: 1 cycle from load to o_vld/o_dat.
// Backpressure: none; i_flush suppresses the pending pulse and keeps the last committed data.
module rom_arb_resp_reg #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load,
    input  logic                  i_flush,
    input  logic [DATA_WIDTH-1:0] i_dat,
    output logic                  o_vld,
    output logic [DATA_WIDTH-1:0] o_dat
);

    logic                  r_vld;
    logic [DATA_WIDTH-1:0] r_cap;
    logic [DATA_WIDTH-1:0] r_out;
    logic                  w_commit;

    // A captured word becomes visible only if it is not flushed in its delivery cycle;
    // otherwise the consumer keeps seeing the last word it actually accepted.
    assign w_commit = r_vld & ~i_flush;
    assign o_vld    = w_commit;
    assign o_dat    = w_commit ? r_cap : r_out;

    // Capture on load, and remember the delivered word so a flush can fall back to it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= 1'b0;
            r_cap <= '0;
            r_out <= '0;
        end else begin
            r_vld <= i_load;
            if (i_load) begin
                r_cap <= i_dat;
            end
            if (w_commit) begin
                r_out <= r_cap;
            end
        end
    end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares one combinational-read ROM between instruction fetch (IF) and data loads (DM).
// Latency: grant is combinational; read data and rvalid appear the cycle after the grant.
// Backpressure: requesters hold req/addr until gnt; IF is favoured but DM is forced through after MAX_IF_STREAK IF grants.
module rom_port_arbiter
    import rom_arb_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 10,
    parameter int MAX_IF_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    input  logic                  if_flush,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  dm_req,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    output logic                  dm_gnt,
    output logic                  dm_rvalid,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic [ADDR_WIDTH-1:0] rom_a,
    input  logic [DATA_WIDTH-1:0] rom_rd
);

    localparam logic [STREAK_W-1:0] LP_STREAK_LAST = STREAK_W'(MAX_IF_STREAK - 1);
    localparam logic [STREAK_W-1:0] LP_STREAK_SAT  = {STREAK_W{1'b1}};

    owner_t                r_owner;
    owner_t                w_owner_nxt;
    logic [STREAK_W-1:0]   r_streak;
    logic [STREAK_W-1:0]   w_streak_nxt;
    logic [ADDR_WIDTH-1:0] r_last_addr;
    logic [ADDR_WIDTH-1:0] w_rom_a;
    logic [1:0]            w_gnt;

    // Grant: DM wins when it owns priority or IF is idle; grants are held off during reset
    always_comb begin
        w_gnt = '0;
        if (rst_n) begin
            if (dm_req && ((r_owner == PRIO_DM) || !if_req)) begin
                w_gnt[DM_PORT] = 1'b1;
            end else if (if_req) begin
                w_gnt[IF_PORT] = 1'b1;
            end
        end
    end

    assign if_gnt = w_gnt[IF_PORT];
    assign dm_gnt = w_gnt[DM_PORT];

    // ROM address follows the granted port, otherwise parks on the last granted address
    always_comb begin
        w_rom_a = r_last_addr;
        if (w_gnt[IF_PORT]) begin
            w_rom_a = if_addr;
        end else if (w_gnt[DM_PORT]) begin
            w_rom_a = dm_addr;
        end
    end

    assign rom_a = w_rom_a;

    // Owner next state: hand priority to DM once IF has used up its streak against a waiting DM
    always_comb begin
        w_owner_nxt = r_owner;
        case (r_owner)
            PRIO_IF: begin
                if (w_gnt[IF_PORT] && dm_req && (r_streak == LP_STREAK_LAST)) begin
                    w_owner_nxt = PRIO_DM;
                end
            end
            PRIO_DM: begin
                // Either DM got its slot or it withdrew; both return priority to IF
                if (w_gnt[DM_PORT] || !dm_req) begin
                    w_owner_nxt = PRIO_IF;
                end
            end
            default: w_owner_nxt = PRIO_IF;
        endcase
    end

    // Streak counts IF grants that made DM wait; any DM grant or DM idle cycle resets it
    always_comb begin
        w_streak_nxt = r_streak;
        if (w_gnt[DM_PORT] || !dm_req) begin
            w_streak_nxt = '0;
        end else if (w_gnt[IF_PORT] && (r_streak != LP_STREAK_SAT)) begin
            w_streak_nxt = r_streak + 1'b1;
        end
    end

    // Arbitration state and parked ROM address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner     <= PRIO_IF;
            r_streak    <= '0;
            r_last_addr <= '0;
        end else begin
            r_owner  <= w_owner_nxt;
            r_streak <= w_streak_nxt;
            if (|w_gnt) begin
                r_last_addr <= w_rom_a;
            end
        end
    end

    rom_arb_resp_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_if_resp (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_gnt[IF_PORT]),
        .i_flush (if_flush),
        .i_dat   (rom_rd),
        .o_vld   (if_rvalid),
        .o_dat   (if_rdata)
    );

    rom_arb_resp_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_dm_resp (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_gnt[DM_PORT]),
        .i_flush (1'b0),
        .i_dat   (rom_rd),
        .o_vld   (dm_rvalid),
        .o_dat   (dm_rdata)
    );

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter with a ROM whose word k is 32'h1000_0000 + k.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Each scenario task compares against hand-computed values and steps the shared counters.
module tb_rom_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [9:0]  if_addr;
    logic        if_gnt;
    logic        if_flush;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic [9:0]  dm_addr;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic [9:0]  rom_a;
    logic [31:0] rom_rd;

    int total = 0;
    int bad   = 0;

    rom_port_arbiter #(
        .DATA_WIDTH    (32),
        .ADDR_WIDTH    (10),
        .MAX_IF_STREAK (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_flush  (if_flush),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_addr   (dm_addr),
        .dm_gnt    (dm_gnt),
        .dm_rvalid (dm_rvalid),
        .dm_rdata  (dm_rdata),
        .rom_a     (rom_a),
        .rom_rd    (rom_rd)
    );

    assign rom_rd = 32'h1000_0000 + {22'd0, rom_a};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to the drive point of the next cycle
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        if_req   = 1'b1;
        dm_req   = 1'b1;
        if_addr  = 10'h055;
        dm_addr  = 10'h066;
        if_flush = 1'b0;
        #2;
        total++; if (if_gnt !== 1'b0) begin bad++; $display("FAIL reset_if_gnt got=%b exp=0", if_gnt); end
        total++; if (dm_gnt !== 1'b0) begin bad++; $display("FAIL reset_dm_gnt got=%b exp=0", dm_gnt); end
        total++; if (if_rvalid !== 1'b0 || dm_rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%b%b exp=00", if_rvalid, dm_rvalid); end
        total++; if (if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h/%h exp=0/0", if_rdata, dm_rdata); end
        @(negedge clk);
        if_req = 1'b0;
        dm_req = 1'b0;
        rst_n  = 1'b1;
        #1;
        total++; if (rom_a !== 10'h000) begin bad++; $display("FAIL reset_rom_a got=%h exp=000", rom_a); end
    endtask

    task automatic test_if_stream();
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            if_req  = 1'b1;
            if_addr = 10'(k);
            @(negedge clk);
            total++; if (if_gnt !== 1'b1 || dm_gnt !== 1'b0) begin bad++; $display("FAIL stream_gnt%0d got=%b%b exp=10", k, if_gnt, dm_gnt); end
            total++; if (rom_a !== 10'(k)) begin bad++; $display("FAIL stream_rom_a%0d got=%h exp=%h", k, rom_a, 10'(k)); end
            if (k > 0) begin
                total++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h1000_0000 + 32'(k - 1)) begin bad++; $display("FAIL stream_resp%0d got=%b/%h exp=1/%h", k, if_rvalid, if_rdata, 32'h1000_0000 + 32'(k - 1)); end
            end
            total++; if (dm_rvalid !== 1'b0) begin bad++; $display("FAIL stream_dm_rvalid%0d got=%b exp=0", k, dm_rvalid); end
        end
        next_cycle();
        if_req = 1'b0;
        @(negedge clk);
        total++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h1000_0002) begin bad++; $display("FAIL stream_last got=%b/%h exp=1/10000002", if_rvalid, if_rdata); end
        total++; if (if_gnt !== 1'b0 || rom_a !== 10'h002) begin bad++; $display("FAIL stream_idle got=%b/%h exp=0/002", if_gnt, rom_a); end
        next_cycle();
        @(negedge clk);
        total++; if (if_rvalid !== 1'b0 || if_rdata !== 32'h1000_0002) begin bad++; $display("FAIL stream_hold got=%b/%h exp=0/10000002", if_rvalid, if_rdata); end
    endtask

    task automatic test_dm_boundary();
        next_cycle();
        dm_req  = 1'b1;
        dm_addr = 10'h3FF;
        @(negedge clk);
        total++; if (dm_gnt !== 1'b1 || if_gnt !== 1'b0) begin bad++; $display("FAIL dm_gnt got=%b%b exp=01", if_gnt, dm_gnt); end
        total++; if (rom_a !== 10'h3FF) begin bad++; $display("FAIL dm_rom_a got=%h exp=3ff", rom_a); end
        next_cycle();
        dm_req = 1'b0;
        @(negedge clk);
        total++; if (dm_rvalid !== 1'b1 || dm_rdata !== 32'h1000_03FF) begin bad++; $display("FAIL dm_resp got=%b/%h exp=1/100003ff", dm_rvalid, dm_rdata); end
        total++; if (if_rvalid !== 1'b0 || rom_a !== 10'h3FF) begin bad++; $display("FAIL dm_side got=%b/%h exp=0/3ff", if_rvalid, rom_a); end
    endtask

    task automatic test_contention();
        logic [9:0] exp_dm_pat;
        exp_dm_pat = 10'b10_0001_0000;
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            if_req  = 1'b1;
            if_addr = 10'h010;
            dm_req  = 1'b1;
            dm_addr = 10'h200;
            @(negedge clk);
            total++; if (dm_gnt !== exp_dm_pat[c] || if_gnt !== ~exp_dm_pat[c]) begin bad++; $display("FAIL contend_c%0d got=if%b dm%b exp=dm%b", c, if_gnt, dm_gnt, exp_dm_pat[c]); end
            total++; if (rom_a !== (exp_dm_pat[c] ? 10'h200 : 10'h010)) begin bad++; $display("FAIL contend_rom_a%0d got=%h", c, rom_a); end
        end
        next_cycle();
        if_req = 1'b0;
        dm_req = 1'b0;
        @(negedge clk);
        total++; if (dm_rvalid !== 1'b1 || dm_rdata !== 32'h1000_0200 || if_rvalid !== 1'b0) begin bad++; $display("FAIL contend_tail got=dm%b/%h if%b exp=1/10000200/0", dm_rvalid, dm_rdata, if_rvalid); end
    endtask

    task automatic test_flush();
        next_cycle();
        if_req  = 1'b1;
        if_addr = 10'h005;
        @(negedge clk);
        total++; if (if_gnt !== 1'b1) begin bad++; $display("FAIL flush_g1 got=%b exp=1", if_gnt); end
        next_cycle();
        if_addr  = 10'h006;
        if_flush = 1'b1;
        @(negedge clk);
        total++; if (if_rvalid !== 1'b0 || if_rdata !== 32'h1000_0010) begin bad++; $display("FAIL flush_drop got=%b/%h exp=0/10000010", if_rvalid, if_rdata); end
        total++; if (if_gnt !== 1'b1 || rom_a !== 10'h006) begin bad++; $display("FAIL flush_gnt got=%b/%h exp=1/006", if_gnt, rom_a); end
        next_cycle();
        if_req   = 1'b0;
        if_flush = 1'b0;
        @(negedge clk);
        total++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h1000_0006) begin bad++; $display("FAIL flush_next got=%b/%h exp=1/10000006", if_rvalid, if_rdata); end
        next_cycle();
        @(negedge clk);
        total++; if (if_rvalid !== 1'b0 || if_rdata !== 32'h1000_0006) begin bad++; $display("FAIL flush_hold got=%b/%h exp=0/10000006", if_rvalid, if_rdata); end
    endtask

    task automatic test_async_reset();
        next_cycle();
        dm_req  = 1'b1;
        dm_addr = 10'h0AB;
        @(negedge clk);
        total++; if (dm_gnt !== 1'b1) begin bad++; $display("FAIL areset_pre_gnt got=%b exp=1", dm_gnt); end
        next_cycle();
        if_req  = 1'b1;
        if_addr = 10'h030;
        @(negedge clk);
        total++; if (dm_rvalid !== 1'b1 || dm_rdata !== 32'h1000_00AB) begin bad++; $display("FAIL areset_pending got=%b/%h exp=1/100000ab", dm_rvalid, dm_rdata); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (dm_rvalid !== 1'b0 || dm_rdata !== 32'h0 || if_rvalid !== 1'b0 || if_rdata !== 32'h0) begin bad++; $display("FAIL areset_clear got=%b/%h %b/%h exp=0/0 0/0", dm_rvalid, dm_rdata, if_rvalid, if_rdata); end
        total++; if (if_gnt !== 1'b0 || dm_gnt !== 1'b0) begin bad++; $display("FAIL areset_gnt got=%b%b exp=00", if_gnt, dm_gnt); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (if_gnt !== 1'b1 || dm_gnt !== 1'b0 || rom_a !== 10'h030) begin bad++; $display("FAIL areset_first got=if%b dm%b a=%h exp=if1 dm0 a=030", if_gnt, dm_gnt, rom_a); end
        total++; if (dm_rvalid !== 1'b0) begin bad++; $display("FAIL areset_lost got=%b exp=0", dm_rvalid); end
        next_cycle();
        @(negedge clk);
        total++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h1000_0030) begin bad++; $display("FAIL areset_resp got=%b/%h exp=1/10000030", if_rvalid, if_rdata); end
    endtask

    task automatic test_dm_withdraw();
        next_cycle();
        if_req = 1'b0;
        dm_req = 1'b0;
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            if_req  = 1'b1;
            if_addr = 10'h040;
            dm_req  = 1'b1;
            dm_addr = 10'h0C0;
            @(negedge clk);
            total++; if (if_gnt !== 1'b1 || dm_gnt !== 1'b0) begin bad++; $display("FAIL wd_streak%0d got=%b%b exp=10", c, if_gnt, dm_gnt); end
        end
        next_cycle();
        dm_req  = 1'b0;
        if_addr = 10'h020;
        @(negedge clk);
        total++; if (if_gnt !== 1'b1 || dm_gnt !== 1'b0 || rom_a !== 10'h020) begin bad++; $display("FAIL wd_drop got=if%b dm%b a=%h exp=if1 dm0 a=020", if_gnt, dm_gnt, rom_a); end
        next_cycle();
        dm_req  = 1'b1;
        if_addr = 10'h021;
        @(negedge clk);
        total++; if (if_gnt !== 1'b1 || dm_gnt !== 1'b0) begin bad++; $display("FAIL wd_back_to_if got=%b%b exp=10", if_gnt, dm_gnt); end
        total++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h1000_0020) begin bad++; $display("FAIL wd_resp got=%b/%h exp=1/10000020", if_rvalid, if_rdata); end
        next_cycle();
        if_req = 1'b0;
        dm_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_if_stream();
        test_dm_boundary();
        test_contention();
        test_flush();
        test_async_reset();
        test_dm_withdraw();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
